apb_regfile: RTL and testbench

- Parametrised register file with one core write port, two combinational core read ports and an APB3 slave port for host read/write of any register.
- Replaces the fixed 8x8 file, whose host path could only write register 7.
- Adds write-first read bypass, core-priority arbitration with bounded APB wait states, and APB error signalling.
- Sits between the core datapath and the APB bridge; the core keeps its single-cycle register access.

---
 rtl/apb_regfile.sv | 127 ++++++++++++
 tb/tb_apb_regfile.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/apb_regfile.sv
// Parametrised register file: one core write port, two combinational core read
// ports, and an APB3 slave giving the host read/write access to every register.
module apb_regfile #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 3,
  parameter int RD_BYPASS = 1,
  parameter int MAX_WAIT  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reg_write_en,
  input  logic [ADDR_W-1:0] reg_write_addr,
  input  logic [DATA_W-1:0] reg_write_data,
  input  logic [ADDR_W-1:0] reg1_read_addr,
  input  logic [ADDR_W-1:0] reg2_read_addr,
  output logic [DATA_W-1:0] reg1_read_data,
  output logic [DATA_W-1:0] reg2_read_data,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W+1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);
  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_ACCESS = 1'b1;

  logic [DATA_W-1:0] regs [DEPTH];
  logic              state;
  logic [3:0]        wait_cnt;
  logic              cap_write;
  logic              cap_misalign;
  logic [ADDR_W-1:0] cap_idx;
  logic [DATA_W-1:0] cap_wdata;

  logic conflict;
  logic transfer;
  logic apb_commit;

  assign conflict   = reg_write_en && (reg_write_addr == cap_idx);
  assign transfer   = (state == ST_ACCESS) && psel && penable;
  assign apb_commit = transfer && cap_write && !cap_misalign && !conflict;

  // Read ports: write-first forwarding of the core write when enabled; forced to 0 in reset
  always_comb begin
    reg1_read_data = regs[reg1_read_addr];
    reg2_read_data = regs[reg2_read_addr];
    if (RD_BYPASS != 0 && reg_write_en && reg_write_addr == reg1_read_addr)
      reg1_read_data = reg_write_data;
    if (RD_BYPASS != 0 && reg_write_en && reg_write_addr == reg2_read_addr)
      reg2_read_data = reg_write_data;
    if (!rst_n) begin
      reg1_read_data = '0;
      reg2_read_data = '0;
    end
  end

  // APB response; the core always wins a same-index write, bounded by WAIT_MAX stalls
  always_comb begin
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = '0;
    if (state == ST_ACCESS) begin
      if (cap_misalign) begin
        pready  = 1'b1;
        pslverr = 1'b1;
      end else if (!cap_write) begin
        pready = 1'b1;
        prdata = regs[cap_idx];
        if (RD_BYPASS != 0 && conflict)
          prdata = reg_write_data;
      end else if (!conflict) begin
        pready = 1'b1;
      end else if (wait_cnt >= WAIT_MAX) begin
        pready  = 1'b1;
        pslverr = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      if (apb_commit)   regs[cap_idx]        <= cap_wdata;
      if (reg_write_en) regs[reg_write_addr] <= reg_write_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      wait_cnt     <= '0;
      cap_write    <= 1'b0;
      cap_misalign <= 1'b0;
      cap_idx      <= '0;
      cap_wdata    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (psel && !penable) begin
            cap_write    <= pwrite;
            cap_idx      <= paddr[ADDR_W+1:2];
            cap_wdata    <= pwdata;
            cap_misalign <= (paddr[1:0] != 2'b00);
            wait_cnt     <= '0;
            state        <= ST_ACCESS;
          end
        end
        default: begin
          if (!psel)
            state <= ST_IDLE;
          else if (transfer && pready)
            state <= ST_IDLE;
          else if (transfer)
            wait_cnt <= wait_cnt + 4'd1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_regfile.sv
// Directed bench for apb_regfile: table-driven core port vectors plus hand-written
// APB sequences for wait states, timeout, misalignment and reset.
module tb_apb_regfile;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       reg_write_en;
  logic [2:0] reg_write_addr;
  logic [7:0] reg_write_data;
  logic [2:0] reg1_read_addr, reg2_read_addr;
  logic [7:0] reg1_read_data, reg2_read_data;
  logic       psel, penable, pwrite;
  logic [4:0] paddr;
  logic [7:0] pwdata, prdata;
  logic       pready, pslverr;

  logic [7:0] nb_rd1, nb_rd2, nb_prdata;
  logic       nb_pready, nb_pslverr;
  logic       nb_psel = 1'b0, nb_penable = 1'b0, nb_pwrite = 1'b0;
  logic [4:0] nb_paddr = '0;
  logic [7:0] nb_pwdata = '0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  apb_regfile #(.DATA_W(8), .ADDR_W(3), .RD_BYPASS(1), .MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .reg_write_en(reg_write_en), .reg_write_addr(reg_write_addr), .reg_write_data(reg_write_data),
    .reg1_read_addr(reg1_read_addr), .reg2_read_addr(reg2_read_addr),
    .reg1_read_data(reg1_read_data), .reg2_read_data(reg2_read_data),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  apb_regfile #(.DATA_W(8), .ADDR_W(3), .RD_BYPASS(0), .MAX_WAIT(4)) dut_nb (
    .clk(clk), .rst_n(rst_n),
    .reg_write_en(reg_write_en), .reg_write_addr(reg_write_addr), .reg_write_data(reg_write_data),
    .reg1_read_addr(reg1_read_addr), .reg2_read_addr(reg2_read_addr),
    .reg1_read_data(nb_rd1), .reg2_read_data(nb_rd2),
    .psel(nb_psel), .penable(nb_penable), .pwrite(nb_pwrite), .paddr(nb_paddr), .pwdata(nb_pwdata),
    .prdata(nb_prdata), .pready(nb_pready), .pslverr(nb_pslverr)
  );

  typedef struct {
    logic       we;
    logic [2:0] wa;
    logic [7:0] wd;
    logic [2:0] r1;
    logic [2:0] r2;
    logic [7:0] e1;
    logic [7:0] e2;
    logic [7:0] n1;
    logic [7:0] n2;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_core(input logic we, input logic [2:0] a, input logic [7:0] d);
    reg_write_en   = we;
    reg_write_addr = a;
    reg_write_data = d;
  endtask

  task automatic rd_check(input logic [2:0] idx, input logic [7:0] exp, input string name);
    @(negedge clk);
    set_core(1'b0, 3'd0, 8'h00);
    reg1_read_addr = idx;
    #1 chk(name, reg1_read_data, exp);
  endtask

  task automatic apb_setup(input logic wr, input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    #1 chk("setup_pready", pready, 1'b0);
  endtask

  task automatic apb_cycle(input logic we, input logic [2:0] wa, input logic [7:0] wd,
                           input logic exp_rdy, input logic exp_err,
                           input logic chk_rd, input logic [7:0] exp_rd, input string name);
    @(negedge clk);
    penable = 1'b1;
    set_core(we, wa, wd);
    #1;
    chk({name, "_pready"}, pready, exp_rdy);
    if (exp_rdy) chk({name, "_pslverr"}, pslverr, exp_err);
    if (chk_rd)  chk({name, "_prdata"}, prdata, exp_rd);
  endtask

  task automatic apb_end();
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    set_core(1'b0, 3'd0, 8'h00);
  endtask

  initial begin
    vecs[0] = '{1'b1, 3'd3, 8'hA5, 3'd3, 3'd0, 8'hA5, 8'h00, 8'h00, 8'h00};
    vecs[1] = '{1'b0, 3'd0, 8'h00, 3'd3, 3'd3, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
    vecs[2] = '{1'b1, 3'd0, 8'h5A, 3'd0, 3'd3, 8'h5A, 8'hA5, 8'h00, 8'hA5};
    vecs[3] = '{1'b1, 3'd3, 8'hC3, 3'd0, 3'd3, 8'h5A, 8'hC3, 8'h5A, 8'hA5};
    vecs[4] = '{1'b0, 3'd0, 8'h00, 3'd3, 3'd0, 8'hC3, 8'h5A, 8'hC3, 8'h5A};
    vecs[5] = '{1'b1, 3'd7, 8'hFF, 3'd6, 3'd7, 8'h00, 8'hFF, 8'h00, 8'h00};
    vecs[6] = '{1'b0, 3'd0, 8'h00, 3'd7, 3'd6, 8'hFF, 8'h00, 8'hFF, 8'h00};

    rst_n = 1'b0;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    reg1_read_addr = 3'd3; reg2_read_addr = 3'd0;
    set_core(1'b1, 3'd3, 8'h77);
    #2;
    chk("rst_pready", pready, 1'b0);
    chk("rst_pslverr", pslverr, 1'b0);
    chk("rst_prdata", prdata, 8'h00);
    chk("rst_rd1_nobypass", reg1_read_data, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    set_core(1'b0, 3'd0, 8'h00);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      set_core(vecs[i].we, vecs[i].wa, vecs[i].wd);
      reg1_read_addr = vecs[i].r1;
      reg2_read_addr = vecs[i].r2;
      #1;
      chk($sformatf("vec%0d_rd1", i), reg1_read_data, vecs[i].e1);
      chk($sformatf("vec%0d_rd2", i), reg2_read_data, vecs[i].e2);
      chk($sformatf("vec%0d_nb_rd1", i), nb_rd1, vecs[i].n1);
      chk($sformatf("vec%0d_nb_rd2", i), nb_rd2, vecs[i].n2);
    end
    @(negedge clk);
    set_core(1'b0, 3'd0, 8'h00);

    // APB write to index 7, then read it back
    apb_setup(1'b1, 5'h1C, 8'h3C);
    apb_cycle(1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, "wr7");
    apb_end();
    rd_check(3'd7, 8'h3C, "wr7_reg");
    apb_setup(1'b0, 5'h1C, 8'h00);
    apb_cycle(1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h3C, "rd7");
    apb_end();

    // Short conflict: two stalls, then the APB write lands
    apb_setup(1'b1, 5'h08, 8'h11);
    apb_cycle(1'b1, 3'd2, 8'h22, 1'b0, 1'b0, 1'b0, 8'h00, "sc1");
    apb_cycle(1'b1, 3'd2, 8'h22, 1'b0, 1'b0, 1'b0, 8'h00, "sc2");
    apb_cycle(1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, "sc3");
    apb_end();
    rd_check(3'd2, 8'h11, "sc_reg2");

    // Timeout: continuous conflict, four stalls then error; core value wins
    apb_setup(1'b1, 5'h08, 8'h44);
    for (int i = 1; i <= 4; i++)
      apb_cycle(1'b1, 3'd2, 8'h50 + 8'(i), 1'b0, 1'b0, 1'b0, 8'h00, $sformatf("to%0d", i));
    apb_cycle(1'b1, 3'd2, 8'h55, 1'b1, 1'b1, 1'b0, 8'h00, "to5");
    apb_end();
    rd_check(3'd2, 8'h55, "to_reg2");

    // Core and APB writes to different indices in the same commit cycle
    apb_setup(1'b1, 5'h10, 8'h12);
    apb_cycle(1'b1, 3'd5, 8'h34, 1'b1, 1'b0, 1'b0, 8'h00, "dual");
    apb_end();
    rd_check(3'd4, 8'h12, "dual_reg4");
    rd_check(3'd5, 8'h34, "dual_reg5");

    // Misaligned read returns 0 even though reg[1] holds data
    @(negedge clk);
    set_core(1'b1, 3'd1, 8'h99);
    apb_setup(1'b0, 5'h05, 8'h00);
    apb_cycle(1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h00, "mis_rd");
    apb_end();
    apb_setup(1'b1, 5'h0E, 8'hEE);
    apb_cycle(1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, "mis_wr");
    apb_end();
    rd_check(3'd3, 8'hC3, "mis_reg3");
    rd_check(3'd1, 8'h99, "mis_reg1");

    // Reset mid-transfer discards the APB write and clears every register
    apb_setup(1'b1, 5'h18, 8'hDD);
    @(negedge clk);
    penable = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("midrst_pready", pready, 1'b0);
    chk("midrst_pslverr", pslverr, 1'b0);
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      reg1_read_addr = 3'(i);
      reg2_read_addr = 3'(7 - i);
      #1;
      chk($sformatf("clr_rd1_%0d", i), reg1_read_data, 8'h00);
      chk($sformatf("clr_rd2_%0d", i), reg2_read_data, 8'h00);
    end
    chk("post_rst_pready", pready, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
